trig_scheduler: RTL and testbench
=================================

Name: trig_scheduler

Overview:
- Sequences the trigger path of the drift4spascharm timecnt FPGA.
- Generates the emulated trigger stream (`trigemu`) with periodic short triggers and periodic long "cycle" pulses.
- Consumes the trigger block outputs (`trigpulse`, `cyclebegin`, `cycleend`) and hands each accepted trigger to readout through a req/ack handshake.
- Counts accepted and lost triggers per cycle and reports the totals to the CPU registers at cycle end.

Parameters:
- EMU_WIDTH, 8, width of an emulated short trigger in clk periods (50 ns at 160 MHz).
- CYCLE_WIDTH, 240, width of an emulated cycle pulse in clk periods (1.5 us; must exceed 160).
- ACK_TIMEOUT, 1023, max clk periods rd_req waits for rd_ack before the request is abandoned.
- CNTW, 16, width of per-cycle trigger counters.

Ports:
- clk  in  1  160 MHz system clock
- reset  in  1  synchronous, active-high reset
- emu_en  in  1  enables the trigger emulator (level)
- emu_period  in  16  clk periods from start of one emulated pulse to start of the next; values < EMU_WIDTH+2 treated as EMU_WIDTH+2
- emu_burst  in  8  short triggers per emulated cycle; 0 = short triggers only, no cycle pulses
- trigemu  out  1  emulated trigger level to trigger block
- trigpulse  in  1  1-clk accepted trigger from trigger block
- cyclebegin  in  1  1-clk pulse, cycle begins
- cycleend  in  1  1-clk pulse, cycle ends
- rd_req  out  1  readout request, held until ack or timeout
- rd_ack  in  1  readout acknowledge
- rd_trignum  out  CNTW  trigger number within cycle for current request
- busy  out  1  high while a readout request is outstanding
- cyc_acc  out  CNTW  accepted triggers in last completed cycle
- cyc_lost  out  CNTW  triggers lost while busy in last completed cycle
- cyc_valid  out  1  1-clk strobe when cyc_acc/cyc_lost update
- ack_err  out  1  sticky; set on timeout, cleared by reset only

Behaviour:
- Reset: all outputs 0; both FSMs go to IDLE; counters 0. Reset mid-operation aborts any pulse or request immediately; `trigemu` drops the next cycle.
- Emulator FSM states: IDLE, SHORT, GAP, LONG.
  - IDLE→SHORT when emu_en=1. Period counter loads emu_period (clamped); burst counter loads 0.
  - SHORT: `trigemu`=1 for exactly EMU_WIDTH clks, then GAP.
  - GAP: `trigemu`=0 until the period counter expires. Burst counter increments at each SHORT exit.
  - GAP exit: if emu_burst≠0 and burst count == emu_burst → LONG, else → SHORT.
  - LONG: `trigemu`=1 for exactly CYCLE_WIDTH clks, then GAP with the period counter reloaded and the burst counter cleared.
  - emu_en=0 in any state: the current SHORT/LONG completes its full width, then → IDLE; emu_en=0 in GAP → IDLE immediately.
  - emu_period/emu_burst are sampled only on entry to SHORT/LONG.
- Readout FSM states: IDLE, REQ.
  - IDLE, trigpulse=1: go to REQ with rd_req=1 and busy=1 on the next clk. rd_trignum = acc count before increment; acc count increments.
  - REQ, rd_ack=1: rd_req and busy drop on the next clk, → IDLE. A new trigpulse in that same cycle is lost, not queued.
  - REQ, trigpulse=1: lost count increments (saturating at all-ones); rd_trignum unchanged.
  - REQ, timeout counter reaches ACK_TIMEOUT without ack: ack_err=1, rd_req=0, → IDLE. The trigger stays counted as accepted.
  - rd_ack in IDLE is ignored.
- Cycle accounting:
  - cycleend: next clk cyc_acc/cyc_lost latch the counts including any same-clk trigpulse, and cyc_valid=1 for 1 clk.
  - cyclebegin: both counts clear. A same-clk trigpulse counts as 1 in the new cycle.
  - Acc count saturates at all-ones.
  - rd_trignum wraps modulo 2^CNTW only through the saturated counter, i.e. it stays all-ones.

Optional Feature:
- Macro TRIG_TIMESTAMP_EN.
- Defined: adds output rd_ts [31:0] and a free-running 32-bit clk counter, cleared by reset and wrapping at 2^32-1→0. rd_ts latches the counter value on the clk trigpulse is seen in IDLE, and is held while rd_req=1.
- Undefined: rd_ts port absent; no counter logic.

Test Plan:
- Emulator: emu_en=1, emu_period=100, emu_burst=3 → trigemu high 8 clks at t=0,100,200; a 240-clk pulse starting at t=300; next short pulse at t=640.
- Handshake: trigpulse, rd_ack 5 clks after rd_req rises → rd_req high exactly 5 clks, rd_trignum=0; second trigger gives rd_trignum=1.
- Loss: trigpulse, then 3 trigpulses during REQ, ack, then cycleend → cyc_acc=1, cyc_lost=3, cyc_valid 1 clk.
- Timeout: trigpulse, no ack → rd_req falls after 1023 clks, ack_err=1 and stays; next trigpulse accepted normally.
- Boundaries: trigpulse coincident with cyclebegin → counted in new cycle; emu_en dropped mid-LONG → pulse completes its full 240 clks; reset asserted in REQ → rd_req=0, busy=0 next clk.
- TRIG_TIMESTAMP_EN: trigpulse at counter value 1000 → rd_ts=1000 held until ack.

Source files
------------

// File: rtl/trig_scheduler.sv
// trig_scheduler: trigger emulator, readout req/ack sequencer and per-cycle trigger accounting.
// Define TRIG_TIMESTAMP_EN to add rd_ts, a 32-bit clk timestamp of each accepted trigger.
module trig_scheduler #(
    parameter int EMU_WIDTH   = 8,
    parameter int CYCLE_WIDTH = 240,
    parameter int ACK_TIMEOUT = 1023,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            emu_en,
    input  logic [15:0]     emu_period,
    input  logic [7:0]      emu_burst,
    output logic            trigemu,
    input  logic            trigpulse,
    input  logic            cyclebegin,
    input  logic            cycleend,
    output logic            rd_req,
    input  logic            rd_ack,
    output logic [CNTW-1:0] rd_trignum,
    output logic            busy,
    output logic [CNTW-1:0] cyc_acc,
    output logic [CNTW-1:0] cyc_lost,
    output logic            cyc_valid,
    output logic            ack_err
`ifdef TRIG_TIMESTAMP_EN
   ,output logic [31:0]     rd_ts
`endif
);

    localparam logic [15:0]    MIN_PERIOD = 16'(EMU_WIDTH + 2);
    localparam logic [15:0]    SHORT_LAST = 16'(EMU_WIDTH - 1);
    localparam logic [15:0]    LONG_LAST  = 16'(CYCLE_WIDTH - 1);
    localparam int             TOW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {E_IDLE, E_SHORT, E_GAP, E_LONG} emu_state_t;
    typedef enum logic {R_IDLE, R_REQ} rd_state_t;

    emu_state_t emu_st;
    rd_state_t  rd_st;

    logic [15:0] period_eff;
    logic [15:0] period_cnt;
    logic [15:0] per_l;
    logic [15:0] width_cnt;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_l;

    logic [CNTW-1:0] acc_cnt;
    logic [CNTW-1:0] lost_cnt;
    logic [CNTW-1:0] acc_base;
    logic [CNTW-1:0] lost_base;
    logic [CNTW-1:0] acc_next;
    logic [CNTW-1:0] lost_next;
    logic            accept;
    logic            lose;
    logic [TOW-1:0]  to_cnt;

    assign period_eff = (emu_period < MIN_PERIOD) ? MIN_PERIOD : emu_period;

    // The period counter runs from the start of each short pulse, so it keeps
    // counting through SHORT and expires at the last GAP clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            emu_st     <= E_IDLE;
            trigemu    <= 1'b0;
            period_cnt <= '0;
            per_l      <= '0;
            width_cnt  <= '0;
            burst_cnt  <= '0;
            burst_l    <= '0;
        end else begin
            case (emu_st)
                E_IDLE: begin
                    trigemu <= 1'b0;
                    if (emu_en) begin
                        emu_st     <= E_SHORT;
                        trigemu    <= 1'b1;
                        width_cnt  <= SHORT_LAST;
                        period_cnt <= period_eff - 16'd1;
                        burst_cnt  <= '0;
                        burst_l    <= emu_burst;
                    end
                end
                E_SHORT: begin
                    period_cnt <= period_cnt - 16'd1;
                    if (width_cnt == 16'd0) begin
                        trigemu   <= 1'b0;
                        burst_cnt <= burst_cnt + 8'd1;
                        emu_st    <= emu_en ? E_GAP : E_IDLE;
                    end else begin
                        width_cnt <= width_cnt - 16'd1;
                    end
                end
                E_GAP: begin
                    if (!emu_en) begin
                        emu_st <= E_IDLE;
                    end else if (period_cnt == 16'd0) begin
                        trigemu <= 1'b1;
                        burst_l <= emu_burst;
                        if (burst_l != 8'd0 && burst_cnt == burst_l) begin
                            emu_st    <= E_LONG;
                            width_cnt <= LONG_LAST;
                            per_l     <= period_eff;
                        end else begin
                            emu_st     <= E_SHORT;
                            width_cnt  <= SHORT_LAST;
                            period_cnt <= period_eff - 16'd1;
                        end
                    end else begin
                        period_cnt <= period_cnt - 16'd1;
                    end
                end
                E_LONG: begin
                    if (width_cnt == 16'd0) begin
                        trigemu    <= 1'b0;
                        burst_cnt  <= '0;
                        period_cnt <= per_l - 16'd1;
                        emu_st     <= emu_en ? E_GAP : E_IDLE;
                    end else begin
                        width_cnt <= width_cnt - 16'd1;
                    end
                end
                default: emu_st <= E_IDLE;
            endcase
        end
    end

    // cyclebegin clears before a same-clk trigger is counted, so that trigger
    // becomes number 0 of the new cycle.
    always_comb begin
        accept    = trigpulse && (rd_st == R_IDLE);
        lose      = trigpulse && (rd_st == R_REQ);
        acc_base  = cyclebegin ? '0 : acc_cnt;
        lost_base = cyclebegin ? '0 : lost_cnt;
        acc_next  = (accept && acc_base != '1) ? acc_base + CNTW'(1) : acc_base;
        lost_next = (lose && lost_base != '1) ? lost_base + CNTW'(1) : lost_base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_st      <= R_IDLE;
            rd_req     <= 1'b0;
            busy       <= 1'b0;
            rd_trignum <= '0;
            to_cnt     <= '0;
            ack_err    <= 1'b0;
            acc_cnt    <= '0;
            lost_cnt   <= '0;
            cyc_acc    <= '0;
            cyc_lost   <= '0;
            cyc_valid  <= 1'b0;
        end else begin
            acc_cnt   <= acc_next;
            lost_cnt  <= lost_next;
            cyc_valid <= cycleend;
            if (cycleend) begin
                cyc_acc  <= acc_next;
                cyc_lost <= lost_next;
            end
            case (rd_st)
                R_IDLE: begin
                    if (trigpulse) begin
                        rd_st      <= R_REQ;
                        rd_req     <= 1'b1;
                        busy       <= 1'b1;
                        rd_trignum <= acc_base;
                        to_cnt     <= '0;
                    end
                end
                R_REQ: begin
                    if (rd_ack) begin
                        rd_st  <= R_IDLE;
                        rd_req <= 1'b0;
                        busy   <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        rd_st   <= R_IDLE;
                        rd_req  <= 1'b0;
                        busy    <= 1'b0;
                        ack_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            rd_ts  <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (accept)
                rd_ts <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_trig_scheduler.sv
// tb_trig_scheduler: directed self-checking bench for trig_scheduler.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_trig_scheduler;

    logic        clk;
    logic        reset;
    logic        emu_en;
    logic [15:0] emu_period;
    logic [7:0]  emu_burst;
    logic        trigemu;
    logic        trigpulse;
    logic        cyclebegin;
    logic        cycleend;
    logic        rd_req;
    logic        rd_ack;
    logic [15:0] rd_trignum;
    logic        busy;
    logic [15:0] cyc_acc;
    logic [15:0] cyc_lost;
    logic        cyc_valid;
    logic        ack_err;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] rd_ts;
`endif

    int checks = 0;
    int passed = 0;

    trig_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .emu_en     (emu_en),
        .emu_period (emu_period),
        .emu_burst  (emu_burst),
        .trigemu    (trigemu),
        .trigpulse  (trigpulse),
        .cyclebegin (cyclebegin),
        .cycleend   (cycleend),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_trignum (rd_trignum),
        .busy       (busy),
        .cyc_acc    (cyc_acc),
        .cyc_lost   (cyc_lost),
        .cyc_valid  (cyc_valid),
        .ack_err    (ack_err)
`ifdef TRIG_TIMESTAMP_EN
       ,.rd_ts      (rd_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        emu_en = 0; emu_period = 0; emu_burst = 0;
        trigpulse = 0; cyclebegin = 0; cycleend = 0; rd_ack = 0;
        do_reset();
        checks++;
        if (trigemu !== 1'b0) $display("[TB] FAIL reset_trigemu got %0b want 0", trigemu); else passed++;
        checks++;
        if (rd_req !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL reset_req got req=%0b busy=%0b want 0/0", rd_req, busy); else passed++;
        checks++;
        if (cyc_acc !== 16'd0 || cyc_lost !== 16'd0 || cyc_valid !== 1'b0)
            $display("[TB] FAIL reset_cyc got acc=%0d lost=%0d valid=%0b want 0/0/0", cyc_acc, cyc_lost, cyc_valid);
        else passed++;
        checks++;
        if (ack_err !== 1'b0 || rd_trignum !== 16'd0)
            $display("[TB] FAIL reset_err got ack_err=%0b trignum=%0d want 0/0", ack_err, rd_trignum);
        else passed++;
    endtask

    task automatic test_emulator();
        int errs = 0;
        int first = -1;
        logic exp;
        do_reset();
        emu_period = 16'd100; emu_burst = 8'd3; emu_en = 1'b1;
        tick();
        for (int t = 0; t < 700; t++) begin
            exp = (t < 8) || (t >= 100 && t < 108) || (t >= 200 && t < 208) ||
                  (t >= 300 && t < 540) || (t >= 640 && t < 648);
            if (trigemu !== exp) begin
                errs++;
                if (first < 0) first = t;
            end
            tick();
        end
        checks++;
        if (errs != 0) $display("[TB] FAIL emu_waveform got %0d bad cycles (first t=%0d) want 0", errs, first); else passed++;
        emu_en = 1'b0;
        errs = 0;
        for (int t = 0; t < 200; t++) begin
            if (trigemu !== 1'b0) errs++;
            tick();
        end
        checks++;
        if (errs != 0) $display("[TB] FAIL emu_stop_gap got %0d high cycles want 0", errs); else passed++;
    endtask

    task automatic test_emu_clamp();
        int errs = 0;
        do_reset();
        emu_period = 16'd0; emu_burst = 8'd0; emu_en = 1'b1;
        tick();
        for (int t = 0; t < 40; t++) begin
            if (trigemu !== ((t % 10) < 8)) errs++;
            tick();
        end
        emu_en = 1'b0;
        checks++;
        if (errs != 0) $display("[TB] FAIL emu_clamp got %0d bad cycles want 0", errs); else passed++;
    endtask

    task automatic test_emu_stop_long();
        int errs = 0;
        int first = -1;
        logic exp;
        do_reset();
        emu_period = 16'd3; emu_burst = 8'd1; emu_en = 1'b1;
        tick();
        for (int t = 0; t < 400; t++) begin
            exp = (t < 8) || (t >= 10 && t < 250);
            if (trigemu !== exp) begin
                errs++;
                if (first < 0) first = t;
            end
            if (t == 100) emu_en = 1'b0;
            tick();
        end
        checks++;
        if (errs != 0) $display("[TB] FAIL emu_stop_long got %0d bad cycles (first t=%0d) want 0", errs, first); else passed++;
    endtask

    task automatic test_handshake();
        int high = 0;
        do_reset();
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || busy !== 1'b1 || rd_trignum !== 16'd0)
            $display("[TB] FAIL hs_first got req=%0b busy=%0b num=%0d want 1/1/0", rd_req, busy, rd_trignum);
        else passed++;
        for (int k = 0; k < 20; k++) begin
            if (rd_req) high++;
            rd_ack = (k == 4);
            tick();
        end
        rd_ack = 1'b0;
        checks++;
        if (high != 5) $display("[TB] FAIL hs_req_width got %0d want 5", high); else passed++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL hs_busy_drop got %0b want 0", busy); else passed++;
        rd_ack = 1'b1;
        tick();
        tick();
        rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0 || ack_err !== 1'b0)
            $display("[TB] FAIL hs_idle_ack got req=%0b err=%0b want 0/0", rd_req, ack_err);
        else passed++;
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || rd_trignum !== 16'd1)
            $display("[TB] FAIL hs_second got req=%0b num=%0d want 1/1", rd_req, rd_trignum);
        else passed++;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_loss();
        do_reset();
        cyclebegin = 1'b1;
        tick();
        cyclebegin = 1'b0;
        trigpulse = 1'b1;
        tick();
        tick();
        tick();
        tick();
        trigpulse = 1'b0;
        checks++;
        if (rd_trignum !== 16'd0) $display("[TB] FAIL loss_trignum got %0d want 0", rd_trignum); else passed++;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        cycleend = 1'b1;
        tick();
        cycleend = 1'b0;
        checks++;
        if (cyc_valid !== 1'b1 || cyc_acc !== 16'd1 || cyc_lost !== 16'd3)
            $display("[TB] FAIL loss_report got valid=%0b acc=%0d lost=%0d want 1/1/3", cyc_valid, cyc_acc, cyc_lost);
        else passed++;
        tick();
        checks++;
        if (cyc_valid !== 1'b0 || cyc_acc !== 16'd1 || cyc_lost !== 16'd3)
            $display("[TB] FAIL loss_hold got valid=%0b acc=%0d lost=%0d want 0/1/3", cyc_valid, cyc_acc, cyc_lost);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        trigpulse = 1'b1;
        tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        trigpulse = 1'b0;
        checks++;
        if (rd_req !== 1'b0) $display("[TB] FAIL b2b_ack_drop got %0b want 0", rd_req); else passed++;
        trigpulse = 1'b1;
        cycleend = 1'b1;
        tick();
        trigpulse = 1'b0;
        cycleend = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || rd_trignum !== 16'd1)
            $display("[TB] FAIL b2b_accept got req=%0b num=%0d want 1/1", rd_req, rd_trignum);
        else passed++;
        checks++;
        if (cyc_valid !== 1'b1 || cyc_acc !== 16'd2 || cyc_lost !== 16'd1)
            $display("[TB] FAIL b2b_cycleend got valid=%0b acc=%0d lost=%0d want 1/2/1", cyc_valid, cyc_acc, cyc_lost);
        else passed++;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_cyclebegin();
        do_reset();
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        cyclebegin = 1'b1;
        trigpulse = 1'b1;
        tick();
        cyclebegin = 1'b0;
        trigpulse = 1'b0;
        checks++;
        if (rd_trignum !== 16'd0) $display("[TB] FAIL cb_trignum got %0d want 0", rd_trignum); else passed++;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        cycleend = 1'b1;
        tick();
        cycleend = 1'b0;
        checks++;
        if (cyc_acc !== 16'd1 || cyc_lost !== 16'd0)
            $display("[TB] FAIL cb_count got acc=%0d lost=%0d want 1/0", cyc_acc, cyc_lost);
        else passed++;
    endtask

    task automatic test_timeout();
        int high = 0;
        do_reset();
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            if (rd_req) high++;
            tick();
        end
        checks++;
        if (high != 1023) $display("[TB] FAIL to_req_width got %0d want 1023", high); else passed++;
        checks++;
        if (ack_err !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL to_err got err=%0b busy=%0b want 1/0", ack_err, busy);
        else passed++;
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || rd_trignum !== 16'd1)
            $display("[TB] FAIL to_next got req=%0b num=%0d want 1/1", rd_req, rd_trignum);
        else passed++;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        checks++;
        if (ack_err !== 1'b1 || rd_req !== 1'b0)
            $display("[TB] FAIL to_sticky got err=%0b req=%0b want 1/0", ack_err, rd_req);
        else passed++;
    endtask

    task automatic test_reset_in_req();
        do_reset();
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (rd_req !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL rst_req got req=%0b busy=%0b want 0/0", rd_req, busy);
        else passed++;
    endtask

`ifdef TRIG_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        for (int k = 0; k < 1000; k++) tick();
        trigpulse = 1'b1;
        tick();
        trigpulse = 1'b0;
        checks++;
        if (rd_ts !== 32'd1000) $display("[TB] FAIL ts_latch got %0d want 1000", rd_ts); else passed++;
        tick();
        tick();
        tick();
        checks++;
        if (rd_ts !== 32'd1000) $display("[TB] FAIL ts_hold got %0d want 1000", rd_ts); else passed++;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0;
        test_reset();
        test_emulator();
        test_emu_clamp();
        test_emu_stop_long();
        test_handshake();
        test_loss();
        test_back_to_back();
        test_cyclebegin();
        test_timeout();
        test_reset_in_req();
`ifdef TRIG_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
